// File: rtl/fetch_controller_if.sv
// Fetch controller bus bundle: instruction-memory port, pipeline controls
// and the registered IF/ID outputs.
interface fetch_controller_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        resume;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        fault;
    logic [1:0]  state;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        input  resume,
        output if_valid,
        output if_instr,
        output if_pc,
        output if_pc_plus4,
        output fault,
        output state
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output stall,
        output redirect_valid,
        output redirect_pc,
        output halt,
        output resume,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus4,
        input  fault,
        input  state
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC ownership, IF/ID register, halt/redirect.
// Optional out-of-range fetch fault enabled by FETCH_BOUNDS_CHECK_EN.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'd40,
    parameter int unsigned MEM_WORDS = 250
) (
    input  logic               clk,
    input  logic               reset,
    fetch_controller_if.master fif
);
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic [31:0] target;
    logic        fetch_oob;

    if ({2'b00, RESET_PC[31:2]} >= MEM_WORDS) begin : g_bad_reset_pc
        $error("RESET_PC lies outside instruction memory");
    end

    // Misaligned redirect targets are silently aligned down
    assign target = fif.redirect_pc & ~32'd3;

`ifdef FETCH_BOUNDS_CHECK_EN
    assign fetch_oob = {2'b00, pc_q[31:2]} >= MEM_WORDS;
    // FAULT is only left through reset, so the state alone is sticky
    assign fif.fault = (state_q == FAULT);
`else
    assign fetch_oob = 1'b0;
    assign fif.fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (fif.redirect_valid) begin
                    pc_d       = target;
                    if_valid_d = 1'b0;
                end else if (!fif.stall) begin
                    if (fetch_oob) begin
                        if_valid_d = 1'b0;
                        state_d    = FAULT;
                    end else begin
                        if_instr_d = fif.imem_instr;
                        if_pc_d    = pc_q;
                        if_pc4_d   = pc_q + 32'd4;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                    end
                end
                // The selected action completes, then fetching stops
                if (fif.halt && state_d == RUN) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if_valid_d = 1'b0;
                if (fif.redirect_valid) begin
                    pc_d = target;
                end
                if (fif.resume && !fif.halt) begin
                    state_d = RUN;
                end
            end
            FAULT: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign fif.imem_addr   = pc_q;
    assign fif.if_valid    = if_valid_q;
    assign fif.if_instr    = if_instr_q;
    assign fif.if_pc       = if_pc_q;
    assign fif.if_pc_plus4 = if_pc4_q;
    assign fif.state       = state_q;
endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller.
// Instruction memory is a pure function of the word address.
module tb_fetch_controller;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_controller_if fif ();

    fetch_controller dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif.master)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd40) return 32'h2008_0005;
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign fif.imem_instr = mem_word(fif.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fif.stall = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.redirect_pc = '0;
        fif.halt = 1'b0;
        fif.resume = 1'b0;
        #3;
        checks++;
        if (fif.state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", fif.state);
        end
        checks++;
        if (fif.imem_addr !== 32'd40) begin
            errors++;
            $display("FAIL reset_pc: got %h want 28", fif.imem_addr);
        end
        checks++;
        if ({fif.if_valid, fif.if_instr, fif.if_pc,
             fif.if_pc_plus4, fif.fault} !== '0) begin
            errors++;
            $display("FAIL reset_outs: v=%b i=%h p=%h p4=%h f=%b want all 0",
                     fif.if_valid, fif.if_instr, fif.if_pc,
                     fif.if_pc_plus4, fif.fault);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_boot_fetch();
        step();
        checks++;
        if (fif.state !== 2'd1 || fif.if_valid !== 1'b0
            || fif.imem_addr !== 32'd40) begin
            errors++;
            $display("FAIL boot_cycle: st=%0d v=%b a=%h want 1 0 28",
                     fif.state, fif.if_valid, fif.imem_addr);
        end
        step();
        checks++;
        if (fif.if_valid !== 1'b1 || fif.if_pc !== 32'd40
            || fif.if_instr !== 32'h2008_0005
            || fif.if_pc_plus4 !== 32'd44) begin
            errors++;
            $display("FAIL first_fetch: v=%b pc=%h i=%h p4=%h want 1 28 20080005 2c",
                     fif.if_valid, fif.if_pc, fif.if_instr, fif.if_pc_plus4);
        end
        step();
        checks++;
        if (fif.if_pc !== 32'd44 || fif.if_instr !== (32'hC0DE_0000 ^ 32'd44)
            || fif.if_pc_plus4 !== 32'd48 || fif.imem_addr !== 32'd48) begin
            errors++;
            $display("FAIL second_fetch: pc=%h i=%h p4=%h a=%h want 2c c0de002c 30 30",
                     fif.if_pc, fif.if_instr, fif.if_pc_plus4, fif.imem_addr);
        end
    endtask

    task automatic test_stall();
        fif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (fif.if_pc !== 32'd44 || fif.imem_addr !== 32'd48
                || fif.if_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: pc=%h a=%h v=%b want 2c 30 1",
                         i, fif.if_pc, fif.imem_addr, fif.if_valid);
            end
        end
        fif.stall = 1'b0;
        step();
        checks++;
        if (fif.if_pc !== 32'd48 || fif.if_instr !== (32'hC0DE_0000 ^ 32'd48)
            || fif.imem_addr !== 32'd52) begin
            errors++;
            $display("FAIL stall_resume: pc=%h i=%h a=%h want 30 c0de0030 34",
                     fif.if_pc, fif.if_instr, fif.imem_addr);
        end
    endtask

    task automatic test_redirect();
        fif.stall = 1'b1;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc = 32'h66;
        step();
        fif.stall = 1'b0;
        fif.redirect_valid = 1'b0;
        checks++;
        if (fif.imem_addr !== 32'h64 || fif.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_squash: a=%h v=%b want 64 0",
                     fif.imem_addr, fif.if_valid);
        end
        step();
        checks++;
        if (fif.if_pc !== 32'h64 || fif.if_valid !== 1'b1
            || fif.if_pc_plus4 !== 32'h68) begin
            errors++;
            $display("FAIL redirect_target: pc=%h v=%b p4=%h want 64 1 68",
                     fif.if_pc, fif.if_valid, fif.if_pc_plus4);
        end
    endtask

    task automatic test_back_to_back();
        fif.stall = 1'b1;
        step();
        fif.stall = 1'b0;
        checks++;
        if (fif.if_pc !== 32'h64 || fif.imem_addr !== 32'h68) begin
            errors++;
            $display("FAIL stall1_hold: pc=%h a=%h want 64 68",
                     fif.if_pc, fif.imem_addr);
        end
        step();
        checks++;
        if (fif.if_pc !== 32'h68 || fif.imem_addr !== 32'h6C) begin
            errors++;
            $display("FAIL stall1_next: pc=%h a=%h want 68 6c",
                     fif.if_pc, fif.imem_addr);
        end
    endtask

    task automatic test_halt();
        fif.halt = 1'b1;
        step();
        fif.halt = 1'b0;
        checks++;
        if (fif.if_pc !== 32'h6C || fif.state !== 2'd2
            || fif.imem_addr !== 32'h70) begin
            errors++;
            $display("FAIL halt_entry: pc=%h st=%0d a=%h want 6c 2 70",
                     fif.if_pc, fif.state, fif.imem_addr);
        end
        step();
        checks++;
        if (fif.if_valid !== 1'b0 || fif.state !== 2'd2
            || fif.imem_addr !== 32'h70) begin
            errors++;
            $display("FAIL halted_idle: v=%b st=%0d a=%h want 0 2 70",
                     fif.if_valid, fif.state, fif.imem_addr);
        end
        fif.halt = 1'b1;
        fif.resume = 1'b1;
        step();
        checks++;
        if (fif.state !== 2'd2) begin
            errors++;
            $display("FAIL resume_with_halt: st=%0d want 2", fif.state);
        end
        fif.halt = 1'b0;
        fif.resume = 1'b0;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc = 32'h81;
        step();
        fif.redirect_valid = 1'b0;
        checks++;
        if (fif.imem_addr !== 32'h80 || fif.state !== 2'd2
            || fif.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL halted_redirect: a=%h st=%0d v=%b want 80 2 0",
                     fif.imem_addr, fif.state, fif.if_valid);
        end
        fif.resume = 1'b1;
        step();
        fif.resume = 1'b0;
        checks++;
        if (fif.state !== 2'd1 || fif.if_valid !== 1'b0
            || fif.imem_addr !== 32'h80) begin
            errors++;
            $display("FAIL resume_edge: st=%0d v=%b a=%h want 1 0 80",
                     fif.state, fif.if_valid, fif.imem_addr);
        end
        step();
        checks++;
        if (fif.if_valid !== 1'b1 || fif.if_pc !== 32'h80
            || fif.if_instr !== (32'hC0DE_0000 ^ 32'h80)) begin
            errors++;
            $display("FAIL resume_fetch: v=%b pc=%h i=%h want 1 80 c0de0080",
                     fif.if_valid, fif.if_pc, fif.if_instr);
        end
    endtask

    task automatic test_bounds();
        fif.redirect_valid = 1'b1;
        fif.redirect_pc = 32'd1000;
        step();
        fif.redirect_valid = 1'b0;
        checks++;
        if (fif.imem_addr !== 32'd1000 || fif.state !== 2'd1) begin
            errors++;
            $display("FAIL oob_redirect: a=%h st=%0d want 3e8 1",
                     fif.imem_addr, fif.state);
        end
        step();
`ifdef FETCH_BOUNDS_CHECK_EN
        checks++;
        if (fif.fault !== 1'b1 || fif.state !== 2'd3
            || fif.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL oob_fault: f=%b st=%0d v=%b want 1 3 0",
                     fif.fault, fif.state, fif.if_valid);
        end
        fif.redirect_valid = 1'b1;
        fif.redirect_pc = 32'd40;
        fif.resume = 1'b1;
        step();
        step();
        fif.redirect_valid = 1'b0;
        fif.resume = 1'b0;
        checks++;
        if (fif.fault !== 1'b1 || fif.state !== 2'd3
            || fif.imem_addr !== 32'd1000 || fif.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky: f=%b st=%0d a=%h v=%b want 1 3 3e8 0",
                     fif.fault, fif.state, fif.imem_addr, fif.if_valid);
        end
`else
        checks++;
        if (fif.fault !== 1'b0 || fif.if_valid !== 1'b1
            || fif.if_pc !== 32'd1000
            || fif.if_instr !== (32'hC0DE_0000 ^ 32'd1000)) begin
            errors++;
            $display("FAIL oob_fetch: f=%b v=%b pc=%h i=%h want 0 1 3e8 c0de03e8",
                     fif.fault, fif.if_valid, fif.if_pc, fif.if_instr);
        end
        fif.redirect_valid = 1'b1;
        fif.redirect_pc = 32'hFFFF_FFFC;
        step();
        fif.redirect_valid = 1'b0;
        step();
        checks++;
        if (fif.if_pc !== 32'hFFFF_FFFC || fif.if_pc_plus4 !== 32'd0
            || fif.imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h p4=%h a=%h want fffffffc 0 0",
                     fif.if_pc, fif.if_pc_plus4, fif.imem_addr);
        end
`endif
    endtask

    task automatic test_async_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        step();
        step();
        step();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (fif.state !== 2'd0 || fif.imem_addr !== 32'd40
            || fif.if_valid !== 1'b0 || fif.if_pc !== 32'd0
            || fif.if_instr !== 32'd0 || fif.fault !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: st=%0d a=%h v=%b pc=%h i=%h f=%b",
                     fif.state, fif.imem_addr, fif.if_valid,
                     fif.if_pc, fif.if_instr, fif.fault);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        step();
        checks++;
        if (fif.if_pc !== 32'd40 || fif.if_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_fetch: pc=%h v=%b want 28 1",
                     fif.if_pc, fif.if_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_boot_fetch();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_halt();
        test_bounds();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer for the single-cycle/pipelined MIPS core. It owns the program counter, drives the read address of the combinational `instructionmemory`, and registers the returned word into the IF/ID boundary with a valid flag. It handles stalls, branch/jump redirects, halt/resume, and an optional out-of-range fetch fault.

## Interface
Parameters:
- `RESET_PC`: default `32'd40`. PC loaded on reset; word 10, where program code starts.
- `MEM_WORDS`: default `250`. Instruction memory depth in words; used by the bounds check.

Ports:
- `clk`: input, 1. Single clock; all state updates on the rising edge.
- `reset`: input, 1. Asynchronous, active-high.
- `imem_addr`: output, 32. Byte address to instruction memory; always equals `pc`.
- `imem_instr`: input, 32. Combinational read data for `imem_addr`.
- `stall`: input, 1. Hold the PC and the IF/ID outputs.
- `redirect_valid`: input, 1. Branch/jump taken this cycle.
- `redirect_pc`: input, 32. Redirect target byte address.
- `halt`: input, 1. Request to stop fetching.
- `resume`: input, 1. Leave HALTED.
- `if_valid`: output, 1. `if_instr` and `if_pc` hold a live instruction.
- `if_instr`: output, 32. Registered instruction.
- `if_pc`: output, 32. Address of `if_instr`.
- `if_pc_plus4`: output, 32. `if_pc + 4`, registered.
- `fault`: output, 1. Sticky out-of-range fetch flag.
- `state`: output, 2. Current state, for debug.

## Operation
- States: BOOT=0, RUN=1, HALTED=2, FAULT=3.
- Reset (asynchronous) sets:
  - state=BOOT, pc=RESET_PC
  - if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, fault=0
- BOOT: exactly one cycle with no fetch, then RUN unconditionally. `halt` and `redirect_valid` are ignored in BOOT.
- RUN, per edge, priority highest first:
  1. `redirect_valid`: pc←{redirect_pc[31:2],2'b00}, if_valid←0 (squash); ignores `stall`.
  2. `stall`: pc and all `if_*` outputs hold.
  3. Otherwise: if_instr←imem_instr, if_pc←pc, if_pc_plus4←pc+4, if_valid←1, pc←pc+4.
  - If `halt` is also asserted, the selected action above still completes this edge, then state←HALTED.
- HALTED:
  - pc holds; if_valid←0 on the entry edge and stays 0.
  - `redirect_valid` still loads pc.
  - `resume`→RUN next edge; the first fetch happens on the following edge. `resume` together with `halt` stays HALTED.
- FAULT:
  - if_valid=0, pc holds, fault=1.
  - Ignores all inputs. Exit only via `reset`.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0. `imem_addr` is never registered separately from pc.
- A redirect with nonzero low bits is silently aligned down.

## Timing
- Fetch latency: address presented in cycle N; `if_instr` valid after edge N+1.
- Throughput: 1 instruction/cycle in RUN with no stall.
- Redirect penalty: 1 bubble. The edge after the redirect loads pc; the target is fetched on the next edge.
- `stall` is sampled per edge. A stall one cycle wide holds outputs for exactly one cycle.
- Reset asserted mid-operation clears immediately, regardless of clock.

## Configuration
- Macro `FETCH_BOUNDS_CHECK_EN`.
- Defined: in RUN, a fetch (case 3) with pc[31:2] ≥ MEM_WORDS does not capture the word:
  - if_valid←0, fault←1, state←FAULT.
  - Redirects to out-of-range targets are accepted; the fault fires when the fetch is attempted.
- Undefined: no range compare is built; `fault` is tied to 0, FAULT is unreachable, and out-of-range addresses are fetched as-is.

## Test plan
- Reset, then 4 free cycles with memory[10]=0x20080005 → after the BOOT cycle, if_pc=40, if_instr=0x20080005, if_valid=1; next outputs are if_pc=44, 48; if_pc_plus4=if_pc+4.
- Assert `stall` for 3 cycles during RUN at pc=48 → if_* frozen, pc stays 48; fetch resumes at 48 with no skip or duplicate.
- Assert `redirect_valid` with `redirect_pc`=0x66 and `stall`=1 → pc=0x64; one cycle if_valid=0; next cycle if_pc=0x64.
- Assert `halt` in RUN at pc=52 → that fetch completes (if_pc=52); next cycle if_valid=0, state=2, pc=56. `resume` → fetch of 56 follows two edges later.
- With `FETCH_BOUNDS_CHECK_EN` defined, redirect to 1000 → fault=1, state=3, if_valid=0; further redirects are ignored until `reset`. Without the macro, the fetch proceeds and fault=0.
- Assert `reset` asynchronously mid-RUN → all outputs reach reset values before the next clock edge, and pc=40.
